riscv_perf_monitor: RTL and testbench

RISCV_PERF_MONITOR -- requirements
Module: riscv_perf_monitor

---
 rtl/riscv_perf_monitor_if.sv | 40 ++++
 rtl/riscv_perf_monitor.sv | 171 +++++++++++++++++
 tb/tb_riscv_perf_monitor.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_perf_monitor_if.sv
// Bundle of the pipeline event inputs, the counter readout port and the
// branch-trace pop port of riscv_perf_monitor. The core side drives through
// the master modport and the monitor sits on the slave modport.
interface riscv_perf_monitor_if #(
    parameter int CNT_W       = 32,
    parameter int TRACE_DEPTH = 16,
    parameter int XLEN        = 32
);
    localparam int LVL_W = $clog2(TRACE_DEPTH) + 1;

    logic             enable;
    logic             clear;
    logic [XLEN-1:0]  PC_MEM;
    logic             PCSrc;
    logic             pipeline_stall;
    logic [1:0]       forwardA;
    logic [1:0]       forwardB;
    logic [2:0]       cnt_sel;
    logic [CNT_W-1:0] cnt_data;
    logic             trace_rd_en;
    logic [XLEN-1:0]  trace_data;
    logic             trace_empty;
    logic             trace_full;
    logic [LVL_W-1:0] trace_level;
    logic             trace_ovf;

    modport master (
        output enable, clear, PC_MEM, PCSrc, pipeline_stall,
               forwardA, forwardB, cnt_sel, trace_rd_en,
        input  cnt_data, trace_data, trace_empty, trace_full,
               trace_level, trace_ovf
    );

    modport slave (
        input  enable, clear, PC_MEM, PCSrc, pipeline_stall,
               forwardA, forwardB, cnt_sel, trace_rd_en,
        output cnt_data, trace_data, trace_empty, trace_full,
               trace_level, trace_ovf
    );
endinterface

// File: rtl/riscv_perf_monitor.sv
// RISC-V pipeline performance monitor: five saturating event counters
// (cycles, stalls, forwardA, forwardB, taken branches) with a muxed readout,
// plus an optional FIFO that records the MEM-stage PC of each taken branch.
// The branch-trace buffer is only built when the macro PERF_TRACE_EN is
// defined; otherwise the trace outputs are tied to an idle, empty buffer.
module riscv_perf_monitor #(
    parameter int CNT_W       = 32,
    parameter int TRACE_DEPTH = 16,
    parameter int XLEN        = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    riscv_perf_monitor_if.slave  bus
);
    localparam int NUM_CNT = 5;
    localparam int CNT_CYC   = 0;
    localparam int CNT_STALL = 1;
    localparam int CNT_FWDA  = 2;
    localparam int CNT_FWDB  = 3;
    localparam int CNT_BR    = 4;

    localparam int LVL_W = $clog2(TRACE_DEPTH) + 1;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NUM_CNT-1:0] cnt_inc;
    logic [CNT_W-1:0]   cnt_q [NUM_CNT];
    logic [CNT_W-1:0]   cnt_d [NUM_CNT];
    logic [CNT_W-1:0]   cnt_rd;

    // Decode which events occurred this cycle; nothing counts while disabled
    always_comb begin
        cnt_inc = '0;
        if (bus.enable) begin
            cnt_inc[CNT_CYC]   = 1'b1;
            cnt_inc[CNT_STALL] = bus.pipeline_stall;
            cnt_inc[CNT_FWDA]  = (bus.forwardA != 2'b00);
            cnt_inc[CNT_FWDB]  = (bus.forwardB != 2'b00);
            cnt_inc[CNT_BR]    = bus.PCSrc;
        end
    end

    // Saturating counter next-state; clear wins over any increment
    always_comb begin
        for (int i = 0; i < NUM_CNT; i++) begin
            cnt_d[i] = cnt_q[i];
            if (bus.clear) begin
                cnt_d[i] = '0;
            end else if (cnt_inc[i] && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Combinational readout mux; unused select codes read as zero
    always_comb begin
        cnt_rd = '0;
        case (bus.cnt_sel)
            3'd0:    cnt_rd = cnt_q[CNT_CYC];
            3'd1:    cnt_rd = cnt_q[CNT_STALL];
            3'd2:    cnt_rd = cnt_q[CNT_FWDA];
            3'd3:    cnt_rd = cnt_q[CNT_FWDB];
            3'd4:    cnt_rd = cnt_q[CNT_BR];
            default: cnt_rd = '0;
        endcase
    end

    assign bus.cnt_data = cnt_rd;

`ifdef PERF_TRACE_EN
    // Depth is a power of two, so the pointers wrap naturally at PTR_W bits
    localparam int PTR_W = $clog2(TRACE_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(TRACE_DEPTH);

    logic [XLEN-1:0]  mem_q [TRACE_DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             ovf_q, ovf_d;
    logic             is_empty, is_full;
    logic             push_req, pop_ok, push_ok;

    // FIFO control: a pop frees the slot a same-cycle push needs when full,
    // and an unserviceable push is dropped and flagged instead
    always_comb begin
        is_empty = (level_q == '0);
        is_full  = (level_q == LVL_FULL);
        push_req = bus.enable && bus.PCSrc && !bus.clear;
        pop_ok   = bus.trace_rd_en && !is_empty && !bus.clear;
        push_ok  = push_req && (!is_full || pop_ok);

        head_d  = head_q;
        tail_d  = tail_q;
        level_d = level_q;
        ovf_d   = ovf_q;

        if (bus.clear) begin
            head_d  = '0;
            tail_d  = '0;
            level_d = '0;
            ovf_d   = 1'b0;
        end else begin
            if (push_ok) begin
                tail_d = tail_q + PTR_ONE;
            end
            if (pop_ok) begin
                head_d = head_q + PTR_ONE;
            end
            if (push_ok && !pop_ok) begin
                level_d = level_q + LVL_ONE;
            end else if (!push_ok && pop_ok) begin
                level_d = level_q - LVL_ONE;
            end
            if (push_req && is_full && !pop_ok) begin
                ovf_d = 1'b1;
            end
        end
    end

    // Pointer, occupancy and overflow registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
        end
    end

    // Trace storage; contents need no reset because reads are gated by empty
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[tail_q] <= bus.PC_MEM;
        end
    end

    assign bus.trace_empty = is_empty;
    assign bus.trace_full  = is_full;
    assign bus.trace_level = level_q;
    assign bus.trace_ovf   = ovf_q;
    assign bus.trace_data  = is_empty ? {XLEN{1'b0}} : mem_q[head_q];
`else
    // No trace storage: present a permanently empty, never-overflowing buffer
    assign bus.trace_empty = 1'b1;
    assign bus.trace_full  = 1'b0;
    assign bus.trace_level = {LVL_W{1'b0}};
    assign bus.trace_ovf   = 1'b0;
    assign bus.trace_data  = {XLEN{1'b0}};
`endif
endmodule

// File: tb/tb_riscv_perf_monitor.sv
// Testbench for riscv_perf_monitor. Two instances run in lockstep from the
// same stimulus: a wide one (CNT_W=32, TRACE_DEPTH=16) and a narrow one
// (CNT_W=4, TRACE_DEPTH=4) so saturation and buffer-full corners are reached
// quickly. A queue-based reference model is compared every cycle, and
// directed sequences pin the model with hand-computed values.
module tb_riscv_perf_monitor;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic        pcsrc = 1'b0;
    logic        stall = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] pc_mem = 32'h0;
    logic [1:0]  fwd_a = 2'd0;
    logic [1:0]  fwd_b = 2'd0;
    logic [2:0]  cnt_sel = 3'd0;

    int checks = 0;
    int failures = 0;

    longint unsigned m_cnt [2][5];
    logic [31:0]     m_q [2][$];
    bit              m_ovf [2];

    always #5 clk = ~clk;

    riscv_perf_monitor_if #(.CNT_W(32), .TRACE_DEPTH(16), .XLEN(32)) bus_a ();
    riscv_perf_monitor_if #(.CNT_W(4),  .TRACE_DEPTH(4),  .XLEN(32)) bus_b ();

    assign bus_a.enable = enable;
    assign bus_a.clear = clear;
    assign bus_a.PC_MEM = pc_mem;
    assign bus_a.PCSrc = pcsrc;
    assign bus_a.pipeline_stall = stall;
    assign bus_a.forwardA = fwd_a;
    assign bus_a.forwardB = fwd_b;
    assign bus_a.cnt_sel = cnt_sel;
    assign bus_a.trace_rd_en = rd_en;

    assign bus_b.enable = enable;
    assign bus_b.clear = clear;
    assign bus_b.PC_MEM = pc_mem;
    assign bus_b.PCSrc = pcsrc;
    assign bus_b.pipeline_stall = stall;
    assign bus_b.forwardA = fwd_a;
    assign bus_b.forwardB = fwd_b;
    assign bus_b.cnt_sel = cnt_sel;
    assign bus_b.trace_rd_en = rd_en;

    riscv_perf_monitor #(.CNT_W(32), .TRACE_DEPTH(16), .XLEN(32)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    riscv_perf_monitor #(.CNT_W(4), .TRACE_DEPTH(4), .XLEN(32)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    function automatic longint unsigned cntMax(int k);
        return (k == 0) ? 64'hFFFF_FFFF : 64'd15;
    endfunction

    function automatic int depthOf(int k);
        return (k == 0) ? 16 : 4;
    endfunction

    task automatic checkOutput(input string name, input longint unsigned act,
                               input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the reference model by one clock edge using the applied inputs
    task automatic modelStep();
        bit ev [5];
        bit push;
        bit pop;
        ev[0] = 1'b1;
        ev[1] = stall;
        ev[2] = (fwd_a != 2'd0);
        ev[3] = (fwd_b != 2'd0);
        ev[4] = pcsrc;
        for (int k = 0; k < 2; k++) begin
            if (reset || clear) begin
                for (int c = 0; c < 5; c++) m_cnt[k][c] = 0;
                m_q[k].delete();
                m_ovf[k] = 1'b0;
            end else begin
                if (enable) begin
                    for (int c = 0; c < 5; c++) begin
                        if (ev[c] && m_cnt[k][c] < cntMax(k)) m_cnt[k][c]++;
                    end
                end
`ifdef PERF_TRACE_EN
                push = enable && pcsrc;
                pop = rd_en && (m_q[k].size() > 0);
                if (push && (m_q[k].size() == depthOf(k)) && !pop) begin
                    m_ovf[k] = 1'b1;
                end else begin
                    if (pop) void'(m_q[k].pop_front());
                    if (push) m_q[k].push_back(pc_mem);
                end
`else
                push = 1'b0;
                pop = 1'b0;
`endif
            end
        end
    endtask

    // Compare every output of both instances against the model
    task automatic compareAll();
        longint unsigned a_cnt, a_lvl, a_dat, a_emp, a_ful, a_ovf;
        longint unsigned e_cnt, e_dat;
        int sz;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                a_cnt = 64'(bus_a.cnt_data);
                a_lvl = 64'(bus_a.trace_level);
                a_dat = 64'(bus_a.trace_data);
                a_emp = 64'(bus_a.trace_empty);
                a_ful = 64'(bus_a.trace_full);
                a_ovf = 64'(bus_a.trace_ovf);
            end else begin
                a_cnt = 64'(bus_b.cnt_data);
                a_lvl = 64'(bus_b.trace_level);
                a_dat = 64'(bus_b.trace_data);
                a_emp = 64'(bus_b.trace_empty);
                a_ful = 64'(bus_b.trace_full);
                a_ovf = 64'(bus_b.trace_ovf);
            end
            sz = m_q[k].size();
            e_cnt = (cnt_sel < 3'd5) ? m_cnt[k][cnt_sel] : 64'd0;
            e_dat = (sz > 0) ? 64'(m_q[k][0]) : 64'd0;
            checkOutput($sformatf("model_cnt_data[%0d] sel=%0d", k, cnt_sel), a_cnt, e_cnt);
            checkOutput($sformatf("model_trace_level[%0d]", k), a_lvl, 64'(sz));
            checkOutput($sformatf("model_trace_data[%0d]", k), a_dat, e_dat);
            checkOutput($sformatf("model_trace_empty[%0d]", k), a_emp, 64'(sz == 0));
            checkOutput($sformatf("model_trace_full[%0d]", k), a_ful, 64'(sz == depthOf(k)));
            checkOutput($sformatf("model_trace_ovf[%0d]", k), a_ovf, 64'(m_ovf[k]));
        end
    endtask

    // Compare process: update the model on each edge, check just after it
    initial begin
        forever begin
            @(posedge clk);
            modelStep();
            #1;
            compareAll();
        end
    end

    // Drive one cycle of inputs at the falling edge and return just after
    // the rising edge that consumes them
    task automatic applyStimulus(input logic en, input logic clr, input logic src,
                                 input logic [31:0] pc, input logic stl,
                                 input logic [1:0] fa, input logic [1:0] fb,
                                 input logic rd, input logic [2:0] sel);
        @(negedge clk);
        enable = en;
        clear = clr;
        pcsrc = src;
        pc_mem = pc;
        stall = stl;
        fwd_a = fa;
        fwd_b = fb;
        rd_en = rd;
        cnt_sel = sel;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle(input logic [2:0] sel);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 2'd0, 1'b0, sel);
    endtask

    task automatic clearCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 2'd0, 2'd0, 1'b0, 3'd0);
    endtask

    task automatic pushCycle(input logic [31:0] pc);
        applyStimulus(1'b1, 1'b0, 1'b1, pc, 1'b0, 2'd0, 2'd0, 1'b0, 3'd4);
    endtask

    task automatic popCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 2'd0, 1'b1, 3'd0);
    endtask

    // Hard stop in case the sequence ever stalls
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequences followed by randomized traffic
    initial begin
        logic [31:0] exp_pc [4];

        #1;
        checkOutput("reset_cnt_data_a", 64'(bus_a.cnt_data), 64'd0);
        checkOutput("reset_trace_empty_b", 64'(bus_b.trace_empty), 64'd1);
        checkOutput("reset_trace_full_b", 64'(bus_b.trace_full), 64'd0);
        checkOutput("reset_trace_data_b", 64'(bus_b.trace_data), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Twenty enabled cycles with no events
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 2'd0, 1'b0, 3'd0);
        end
        checkOutput("cyc20_a", 64'(bus_a.cnt_data), 64'd20);
        checkOutput("cyc20_sat_b", 64'(bus_b.cnt_data), 64'd15);
        checkOutput("cyc20_trace_empty_a", 64'(bus_a.trace_empty), 64'd1);
        for (int s = 1; s < 8; s++) begin
            idleCycle(3'(s));
            checkOutput($sformatf("idle_counter_sel%0d_a", s), 64'(bus_a.cnt_data), 64'd0);
        end
        idleCycle(3'd0);
        checkOutput("cyc_hold_a", 64'(bus_a.cnt_data), 64'd20);

        // Stall saturation on the narrow instance
        clearCycle();
        checkOutput("clear_cyc_a", 64'(bus_a.cnt_data), 64'd0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 2'd0, 2'd0, 1'b0, 3'd1);
        end
        checkOutput("stall_sat_b", 64'(bus_b.cnt_data), 64'd15);
        checkOutput("stall_a", 64'(bus_a.cnt_data), 64'd20);
        idleCycle(3'd0);
        checkOutput("cyc_sat_b", 64'(bus_b.cnt_data), 64'd15);

        // Forwarding counters
        clearCycle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 2'd2, 2'd1, 1'b0, 3'd2);
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 2'd1, 1'b0, 3'd2);
        end
        checkOutput("fwdA_a", 64'(bus_a.cnt_data), 64'd3);
        idleCycle(3'd3);
        checkOutput("fwdB_a", 64'(bus_a.cnt_data), 64'd5);
        checkOutput("fwdB_b", 64'(bus_b.cnt_data), 64'd5);

`ifdef PERF_TRACE_EN
        // Overflow on the 4-deep buffer, then drain in order
        clearCycle();
        pushCycle(32'h10);
        pushCycle(32'h14);
        pushCycle(32'h18);
        pushCycle(32'h1C);
        pushCycle(32'h20);
        checkOutput("ovf_full_b", 64'(bus_b.trace_full), 64'd1);
        checkOutput("ovf_level_b", 64'(bus_b.trace_level), 64'd4);
        checkOutput("ovf_flag_b", 64'(bus_b.trace_ovf), 64'd1);
        checkOutput("ovf_level_a", 64'(bus_a.trace_level), 64'd5);
        exp_pc = '{32'h10, 32'h14, 32'h18, 32'h1C};
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("drain_data_b%0d", i), 64'(bus_b.trace_data), 64'(exp_pc[i]));
            popCycle();
        end
        checkOutput("drain_empty_b", 64'(bus_b.trace_empty), 64'd1);
        checkOutput("drain_data_zero_b", 64'(bus_b.trace_data), 64'd0);
        popCycle();
        checkOutput("pop_empty_level_b", 64'(bus_b.trace_level), 64'd0);
        checkOutput("pop_empty_data_b", 64'(bus_b.trace_data), 64'd0);

        // Push and pop together while full
        clearCycle();
        pushCycle(32'h30);
        pushCycle(32'h34);
        pushCycle(32'h38);
        pushCycle(32'h3C);
        checkOutput("pp_full_b", 64'(bus_b.trace_full), 64'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 2'd0, 2'd0, 1'b1, 3'd0);
        checkOutput("pp_level_b", 64'(bus_b.trace_level), 64'd4);
        checkOutput("pp_ovf_b", 64'(bus_b.trace_ovf), 64'd0);
        exp_pc = '{32'h34, 32'h38, 32'h3C, 32'h40};
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("pp_data_b%0d", i), 64'(bus_b.trace_data), 64'(exp_pc[i]));
            popCycle();
        end
        checkOutput("pp_empty_b", 64'(bus_b.trace_empty), 64'd1);

        // Clear beats a same-cycle branch
        for (int i = 0; i < 5; i++) pushCycle(32'h50 + 32'(4 * i));
        checkOutput("pre_clear_ovf_b", 64'(bus_b.trace_ovf), 64'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h60, 1'b0, 2'd0, 2'd0, 1'b0, 3'd4);
        checkOutput("clear_br_b", 64'(bus_b.cnt_data), 64'd0);
        checkOutput("clear_br_a", 64'(bus_a.cnt_data), 64'd0);
        checkOutput("clear_empty_b", 64'(bus_b.trace_empty), 64'd1);
        checkOutput("clear_ovf_b", 64'(bus_b.trace_ovf), 64'd0);
`else
        // Trace disabled: buffer stays idle while branches are still counted
        clearCycle();
        for (int i = 0; i < 5; i++) pushCycle(32'h10 + 32'(4 * i));
        checkOutput("notrace_br_b", 64'(bus_b.cnt_data), 64'd5);
        checkOutput("notrace_empty_b", 64'(bus_b.trace_empty), 64'd1);
        checkOutput("notrace_level_b", 64'(bus_b.trace_level), 64'd0);
        checkOutput("notrace_ovf_b", 64'(bus_b.trace_ovf), 64'd0);
        checkOutput("notrace_data_b", 64'(bus_b.trace_data), 64'd0);
`endif

        // Reset in the middle of buffered traffic
        pushCycle(32'h70);
        pushCycle(32'h74);
        pushCycle(32'h78);
        @(negedge clk);
        enable = 1'b0;
        pcsrc = 1'b0;
        cnt_sel = 3'd0;
        reset = 1'b1;
        #1;
        checkOutput("midreset_empty_b", 64'(bus_b.trace_empty), 64'd1);
        checkOutput("midreset_level_a", 64'(bus_a.trace_level), 64'd0);
        checkOutput("midreset_cyc_a", 64'(bus_a.cnt_data), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        pushCycle(32'h99);
`ifdef PERF_TRACE_EN
        checkOutput("post_reset_data_b", 64'(bus_b.trace_data), 64'h99);
        checkOutput("post_reset_level_b", 64'(bus_b.trace_level), 64'd1);
`else
        checkOutput("post_reset_data_b", 64'(bus_b.trace_data), 64'd0);
`endif
        checkOutput("post_reset_br_a", 64'(bus_a.cnt_data), 64'd1);

        // Randomized traffic: first a fill-heavy phase, then a drain-heavy one
        for (int n = 0; n < 900; n++) begin
            int rd_pct;
            rd_pct = (n < 400) ? 15 : 60;
            applyStimulus(($urandom_range(0, 9) < 8),
                          ($urandom_range(0, 63) == 0),
                          ($urandom_range(0, 9) < 4),
                          ($urandom & 32'hFFFF_FFFC),
                          ($urandom_range(0, 9) < 3),
                          2'($urandom_range(0, 3)),
                          2'($urandom_range(0, 3)),
                          ($urandom_range(0, 99) < rd_pct),
                          3'($urandom_range(0, 7)));
        end

        idleCycle(3'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
